cam_axi_lite_regbank: RTL and testbench
=======================================

Name: cam_axi_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank for camera interface IPs.
- Provides frame-buffer start address, one-shot capture control, NUM_REGS-2 general-purpose RW registers and one read-only status word.
- Adds independent AW/W acceptance, byte strobes, decoded addresses latched at handshake, and SLVERR for unmapped addresses.
- Sits between the PS GP port and the camera capture / AXI master datapath.

Parameters:
- C_S_AXI_LITE_ADDR_WIDTH, 9, AXI-Lite address width; word index = addr[ADDR_WIDTH-1:2].
- C_S_AXI_LITE_DATA_WIDTH, 32, data width (only 32 supported).
- NUM_REGS, 8, number of RW words (min 2); the status word sits at index NUM_REGS.
- C_FB_START_ADDRESS, 32'h1A00_0000, reset value of reg0.
- ONE_SHOT_PULSE_LENGTH, 20, one_shot_trigger high time in aclk cycles (>=1).

Ports:
- aclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axi_lite_awvalid/awready  in/out  1  write address handshake
- s_axi_lite_awaddr  in  ADDR_WIDTH  write address
- s_axi_lite_wvalid/wready  in/out  1  write data handshake
- s_axi_lite_wdata  in  32  write data
- s_axi_lite_wstrb  in  4  byte enables
- s_axi_lite_bvalid/bready  out/in  1  write response handshake
- s_axi_lite_bresp  out  2  OKAY=00, SLVERR=10
- s_axi_lite_arvalid/arready  in/out  1  read address handshake
- s_axi_lite_araddr  in  ADDR_WIDTH  read address
- s_axi_lite_rvalid/rready  out/in  1  read data handshake
- s_axi_lite_rdata  out  32  read data
- s_axi_lite_rresp  out  2  OKAY/SLVERR
- fb_start_address  out  32  reg0
- init_done  out  1  set by first write to reg0
- one_shot_state  out  1  ctrl bit0
- one_shot_trigger  out  1  pulse, ONE_SHOT_PULSE_LENGTH cycles
- gp_regs  out  (NUM_REGS-2)*32  regs 2..NUM_REGS-1, reg2 in LSBs
- status_in  in  32  sampled into read data at index NUM_REGS

Behaviour:
Reset values:
- awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=00; rdata=0.
- reg0=C_FB_START_ADDRESS; ctrl=0; gp=0; init_done=0; one_shot_trigger=0; pulse counter cleared.

Address map (word index):
- 0: fb_start_address, RW.
- 1: ctrl. bit0 one_shot_state RW. bit1 write-1-to-trigger, reads as trigger-busy. Other bits read 0.
- 2..NUM_REGS-1: gp, RW.
- NUM_REGS: status_in, RO. Writes ignored with OKAY.
- >NUM_REGS: unmapped. Writes ignored with SLVERR; reads return 0 with SLVERR.

Write FSM (W_IDLE, W_RESP):
- AW and W are accepted independently.
- On the awvalid&awready edge, latch the address and drop awready. On the wvalid&wready edge, latch data/strb and drop wready.
- When both are held (same cycle or any order), the next edge commits the write byte-wise per wstrb, sets bvalid=1 with bresp, and enters W_RESP.
- W_RESP: on bvalid&bready, bvalid=0, awready=wready=1, back to W_IDLE.
- Only one outstanding write at a time.

Read FSM (R_IDLE, R_DATA):
- On the arvalid&arready edge: arready=0, rdata/rresp registered from the decoded araddr, rvalid=1 (1-cycle latency).
- rdata/rresp are held stable while rvalid=1 and rready=0.
- On rready: rvalid=0, arready=1.
- The status word is sampled at the AR handshake edge.

Register side effects:
- init_done: set on the commit edge of any write to index 0, even if wstrb=0. Cleared only by reset.
- Trigger: a commit to index 1 with wstrb[0]=1 and wdata[1]=1 starts the pulse. one_shot_trigger=1 from the edge after commit for exactly ONE_SHOT_PULSE_LENGTH cycles.
- Retrigger while busy reloads the counter (pulse extends). Bit1 is never stored.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Reset mid-transaction: outstanding handshakes are abandoned, all state returns to reset values, and no partial write is committed.

Test Plan:
- Reset, then read idx0 -> rdata=32'h1A00_0000, rresp=00, rvalid one cycle after AR handshake; init_done=0.
- AW at cycle n, W at n+3, wdata=32'h1B00_0000, wstrb=F -> commit after n+3, bvalid=1, fb_start_address=32'h1B00_0000, init_done=1; repeat with W before AW -> same result.
- Write idx2 data 32'hAABBCCDD with wstrb=4'b0101 onto 0 -> gp_regs[31:0]=32'h00BB00DD; hold bready=0 for 5 cycles -> bvalid stays 1, awready stays 0.
- Write idx1 data 32'h3 -> one_shot_state=1, one_shot_trigger high exactly 20 cycles; retrigger at pulse cycle 10 -> high 30 cycles total; read idx1 mid-pulse -> 32'h3, after the pulse -> 32'h1.
- status_in=32'h1234_5678, read idx NUM_REGS -> 32'h1234_5678 OKAY; write there -> OKAY, no change; read/write idx NUM_REGS+1 -> SLVERR, rdata=0.
- Assert reset while W_RESP with bready=0 -> bvalid=0, awready=1, all registers back to reset values next cycle.

Source files
------------

// File: rtl/cam_axi_lite_regbank.sv
// AXI4-Lite slave register bank for the camera capture path: frame-buffer base,
// one-shot capture control, general-purpose RW words and a read-only status word.
module cam_axi_lite_regbank #(
  parameter int          C_S_AXI_LITE_ADDR_WIDTH = 9,
  parameter int          C_S_AXI_LITE_DATA_WIDTH = 32,
  parameter int          NUM_REGS                = 8,
  parameter logic [31:0] C_FB_START_ADDRESS      = 32'h1A00_0000,
  parameter int          ONE_SHOT_PULSE_LENGTH   = 20
) (
  input  logic                                aclk,
  input  logic                                reset,
  input  logic                                s_axi_lite_awvalid,
  output logic                                s_axi_lite_awready,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]  s_axi_lite_awaddr,
  input  logic                                s_axi_lite_wvalid,
  output logic                                s_axi_lite_wready,
  input  logic [C_S_AXI_LITE_DATA_WIDTH-1:0]  s_axi_lite_wdata,
  input  logic [3:0]                          s_axi_lite_wstrb,
  output logic                                s_axi_lite_bvalid,
  input  logic                                s_axi_lite_bready,
  output logic [1:0]                          s_axi_lite_bresp,
  input  logic                                s_axi_lite_arvalid,
  output logic                                s_axi_lite_arready,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]  s_axi_lite_araddr,
  output logic                                s_axi_lite_rvalid,
  input  logic                                s_axi_lite_rready,
  output logic [C_S_AXI_LITE_DATA_WIDTH-1:0]  s_axi_lite_rdata,
  output logic [1:0]                          s_axi_lite_rresp,
  output logic [C_S_AXI_LITE_DATA_WIDTH-1:0]  fb_start_address,
  output logic                                init_done,
  output logic                                one_shot_state,
  output logic                                one_shot_trigger,
  output logic [(NUM_REGS-2)*C_S_AXI_LITE_DATA_WIDTH-1:0] gp_regs,
  input  logic [C_S_AXI_LITE_DATA_WIDTH-1:0]  status_in
);

  localparam int DW    = C_S_AXI_LITE_DATA_WIDTH;
  localparam int IDX_W = C_S_AXI_LITE_ADDR_WIDTH - 2;
  localparam int GP_N  = NUM_REGS - 2;
  localparam int CNT_W = $clog2(ONE_SHOT_PULSE_LENGTH + 1);
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic             awready_reg, wready_reg, bvalid_reg;
  logic [1:0]       bresp_reg;
  logic [IDX_W-1:0] aw_idx_reg;
  logic [DW-1:0]    wdata_reg;
  logic [3:0]       wstrb_reg;

  logic             arready_reg, rvalid_reg;
  logic [DW-1:0]    rdata_reg;
  logic [1:0]       rresp_reg;

  logic [DW-1:0]    fb_reg;
  logic             init_done_reg, state_bit_reg;
  logic [CNT_W-1:0] pulse_cnt_reg;

  logic             commit, trigger_load;
  logic [IDX_W-1:0] ar_idx;
  logic [DW-1:0]    rd_data;
  logic [1:0]       rd_resp;
  logic             unused_addr_bits;

  // Byte-lane merge of the latched write data onto an existing register value.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_val,
                                          input logic [DW-1:0] new_val,
                                          input logic [3:0]    strb);
    logic [DW-1:0] result;
    result = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) result[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return result;
  endfunction

  assign unused_addr_bits = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};
  assign ar_idx = s_axi_lite_araddr[C_S_AXI_LITE_ADDR_WIDTH-1:2];

  // Both halves latched while idle: this edge writes the registers.
  assign commit = (w_state_reg == W_IDLE) && !awready_reg && !wready_reg;
  assign trigger_load = commit && (aw_idx_reg == IDX_W'(1)) && wstrb_reg[0] && wdata_reg[1];

  always_ff @(posedge aclk) begin
    if (reset) begin
      w_state_reg <= W_IDLE;
      r_state_reg <= R_IDLE;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    r_state_next = r_state_reg;
    case (w_state_reg)
      W_IDLE:  if (commit) w_state_next = W_RESP;
      W_RESP:  if (s_axi_lite_bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
    case (r_state_reg)
      R_IDLE:  if (s_axi_lite_arvalid && arready_reg) r_state_next = R_DATA;
      R_DATA:  if (s_axi_lite_rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      awready_reg <= 1'b1;
      wready_reg  <= 1'b1;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      aw_idx_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else if (w_state_reg == W_IDLE) begin
      if (s_axi_lite_awvalid && awready_reg) begin
        aw_idx_reg  <= s_axi_lite_awaddr[C_S_AXI_LITE_ADDR_WIDTH-1:2];
        awready_reg <= 1'b0;
      end
      if (s_axi_lite_wvalid && wready_reg) begin
        wdata_reg  <= s_axi_lite_wdata;
        wstrb_reg  <= s_axi_lite_wstrb;
        wready_reg <= 1'b0;
      end
      if (commit) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= (aw_idx_reg > STATUS_IDX) ? RESP_SLVERR : RESP_OKAY;
      end
    end else if (s_axi_lite_bready) begin
      bvalid_reg  <= 1'b0;
      awready_reg <= 1'b1;
      wready_reg  <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      fb_reg        <= C_FB_START_ADDRESS;
      init_done_reg <= 1'b0;
      state_bit_reg <= 1'b0;
    end else if (commit) begin
      if (aw_idx_reg == '0) begin
        fb_reg        <= merge(fb_reg, wdata_reg, wstrb_reg);
        init_done_reg <= 1'b1;
      end
      if (aw_idx_reg == IDX_W'(1) && wstrb_reg[0]) state_bit_reg <= wdata_reg[0];
    end
  end

  // Retriggering reloads the counter, so the pulse is stretched rather than restarted.
  always_ff @(posedge aclk) begin
    if (reset) begin
      pulse_cnt_reg <= '0;
    end else if (trigger_load) begin
      pulse_cnt_reg <= CNT_W'(ONE_SHOT_PULSE_LENGTH);
    end else if (pulse_cnt_reg != '0) begin
      pulse_cnt_reg <= pulse_cnt_reg - 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < GP_N; gi++) begin : g_gp
      logic [DW-1:0] gp_reg;
      always_ff @(posedge aclk) begin
        if (reset) begin
          gp_reg <= '0;
        end else if (commit && aw_idx_reg == IDX_W'(gi + 2)) begin
          gp_reg <= merge(gp_reg, wdata_reg, wstrb_reg);
        end
      end
      assign gp_regs[gi*DW +: DW] = gp_reg;
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    for (int i = 0; i < GP_N; i++) begin
      if (ar_idx == IDX_W'(i + 2)) rd_data = gp_regs[i*DW +: DW];
    end
    if (ar_idx == '0) begin
      rd_data = fb_reg;
    end else if (ar_idx == IDX_W'(1)) begin
      rd_data = {{(DW-2){1'b0}}, one_shot_trigger, state_bit_reg};
    end else if (ar_idx == STATUS_IDX) begin
      rd_data = status_in;
    end else if (ar_idx > STATUS_IDX) begin
      rd_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else if (r_state_reg == R_IDLE) begin
      if (s_axi_lite_arvalid && arready_reg) begin
        arready_reg <= 1'b0;
        rvalid_reg  <= 1'b1;
        rdata_reg   <= rd_data;
        rresp_reg   <= rd_resp;
      end
    end else if (s_axi_lite_rready) begin
      rvalid_reg  <= 1'b0;
      arready_reg <= 1'b1;
    end
  end

  assign s_axi_lite_awready = awready_reg;
  assign s_axi_lite_wready  = wready_reg;
  assign s_axi_lite_bvalid  = bvalid_reg;
  assign s_axi_lite_bresp   = bresp_reg;
  assign s_axi_lite_arready = arready_reg;
  assign s_axi_lite_rvalid  = rvalid_reg;
  assign s_axi_lite_rdata   = rdata_reg;
  assign s_axi_lite_rresp   = rresp_reg;
  assign fb_start_address   = fb_reg;
  assign init_done          = init_done_reg;
  assign one_shot_state     = state_bit_reg;
  assign one_shot_trigger   = (pulse_cnt_reg != '0);

endmodule

// File: tb/tb_cam_axi_lite_regbank.sv
// Bench for cam_axi_lite_regbank: directed scenarios plus randomized traffic
// checked against an array-based register model.
module tb_cam_axi_lite_regbank;

  localparam int AW = 9;
  localparam int NR = 8;
  localparam int PL = 20;
  localparam logic [31:0] FB0 = 32'h1A00_0000;

  logic aclk = 1'b0;
  logic reset = 1'b1;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata, status_in = '0, fb_start_address;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic init_done, one_shot_state, one_shot_trigger;
  logic [(NR-2)*32-1:0] gp_regs;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc_count = 0;
  int trig_count = 0;

  // Register model
  logic [31:0] m_fb;
  logic        m_init, m_state;
  logic [31:0] m_gp [NR-2];

  cam_axi_lite_regbank #(
    .C_S_AXI_LITE_ADDR_WIDTH(AW), .C_S_AXI_LITE_DATA_WIDTH(32), .NUM_REGS(NR),
    .C_FB_START_ADDRESS(FB0), .ONE_SHOT_PULSE_LENGTH(PL)
  ) dut (
    .aclk(aclk), .reset(reset),
    .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready), .s_axi_lite_awaddr(awaddr),
    .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready), .s_axi_lite_wdata(wdata),
    .s_axi_lite_wstrb(wstrb), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
    .s_axi_lite_bresp(bresp), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
    .s_axi_lite_araddr(araddr), .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready),
    .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
    .fb_start_address(fb_start_address), .init_done(init_done),
    .one_shot_state(one_shot_state), .one_shot_trigger(one_shot_trigger),
    .gp_regs(gp_regs), .status_in(status_in)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc_count++;
  always @(negedge aclk) if (one_shot_trigger === 1'b1) trig_count++;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
    return r;
  endfunction

  function automatic void model_reset();
    m_fb = FB0; m_init = 1'b0; m_state = 1'b0;
    for (int i = 0; i < NR-2; i++) m_gp[i] = '0;
  endfunction

  function automatic logic [1:0] model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx > NR) return 2'b10;
    if (idx == 0) begin m_fb = merge(m_fb, d, s); m_init = 1'b1; end
    else if (idx == 1) begin if (s[0]) m_state = d[0]; end
    else if (idx < NR) m_gp[idx-2] = merge(m_gp[idx-2], d, s);
    return 2'b00;
  endfunction

  // Model read with no trigger pulse running.
  function automatic void model_read(input int idx, output logic [31:0] d, output logic [1:0] r);
    d = '0; r = 2'b00;
    if (idx == 0) d = m_fb;
    else if (idx == 1) d = {31'b0, m_state};
    else if (idx < NR) d = m_gp[idx-2];
    else if (idx == NR) d = status_in;
    else r = 2'b10;
  endfunction

  task automatic do_reset();
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    reset = 1'b1;
    @(posedge aclk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_txn(input int idx, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int hold,
                           output logic [1:0] resp, output int commit_cyc);
    int cyc;
    bit aw_done, w_done, hs_aw, hs_w;
    awaddr = AW'(idx * 4); wdata = d; wstrb = s; bready = 1'b0;
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= awd);
      wvalid  = !w_done && (cyc >= wd);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge aclk); #1;
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    tests_run++;
    if (!(aw_done && w_done)) begin
      tests_failed++;
      $display("FAIL wr_accept idx=%0d aw=%0b w=%0b required 1/1", idx, aw_done, w_done);
    end
    cyc = 0;
    while (bvalid !== 1'b1 && cyc < 20) begin @(posedge aclk); #1; cyc++; end
    tests_run++;
    if (cyc !== 1) begin
      tests_failed++;
      $display("FAIL wr_commit_latency idx=%0d got %0d cycles required 1", idx, cyc);
    end
    commit_cyc = cyc_count;
    resp = bresp;
    for (int h = 0; h < hold; h++) begin
      @(posedge aclk); #1;
      tests_run++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
        tests_failed++;
        $display("FAIL wr_backpressure cycle %0d bvalid=%b awready=%b wready=%b required 1/0/0", h, bvalid, awready, wready);
      end
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    tests_run++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_release bvalid=%b awready=%b wready=%b required 0/1/1", bvalid, awready, wready);
    end
    $display("[TB] WR idx=%0d data=%h strb=%h bresp=%0d", idx, d, s, resp);
  endtask

  task automatic read_txn(input int idx, input int hold, output logic [31:0] d, output logic [1:0] r);
    int cyc;
    araddr = AW'(idx * 4); arvalid = 1'b1; rready = 1'b0;
    cyc = 0;
    while (arready !== 1'b1 && cyc < 20) begin @(posedge aclk); #1; cyc++; end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    tests_run++;
    if (rvalid !== 1'b1 || arready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_latency idx=%0d rvalid=%b arready=%b required 1/0", idx, rvalid, arready);
    end
    d = rdata; r = rresp;
    for (int h = 0; h < hold; h++) begin
      @(posedge aclk); #1;
      tests_run++;
      if (rvalid !== 1'b1 || rdata !== d || rresp !== r) begin
        tests_failed++;
        $display("FAIL rd_hold cycle %0d rvalid=%b rdata=%h required 1 and %h", h, rvalid, rdata, d);
      end
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    tests_run++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_release rvalid=%b arready=%b required 0/1", rvalid, arready);
    end
    $display("[TB] RD idx=%0d data=%h rresp=%0d", idx, d, r);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    reset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 reset = 1'b0;
    model_reset();
    tests_run++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      tests_failed++;
      $display("FAIL reset_handshake got %b required 11100", {awready, wready, arready, bvalid, rvalid});
    end
    tests_run++;
    if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_resp bresp=%0d rresp=%0d rdata=%h required 0/0/0", bresp, rresp, rdata);
    end
    tests_run++;
    if (fb_start_address !== FB0 || init_done !== 1'b0 || one_shot_state !== 1'b0 ||
        one_shot_trigger !== 1'b0 || gp_regs !== '0) begin
      tests_failed++;
      $display("FAIL reset_regs fb=%h init=%b state=%b trig=%b gp=%h required %h/0/0/0/0",
               fb_start_address, init_done, one_shot_state, one_shot_trigger, gp_regs, FB0);
    end
    read_txn(0, 0, d, r);
    tests_run++;
    if (d !== 32'h1A00_0000 || r !== 2'b00 || init_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_read0 data=%h resp=%0d init=%b required 1a000000/0/0", d, r, init_done);
    end
  endtask

  task automatic test_write_order();
    logic [1:0] r; int c;
    write_txn(0, 32'h1B00_0000, 4'hF, 0, 3, 0, r, c);
    void'(model_write(0, 32'h1B00_0000, 4'hF));
    tests_run++;
    if (r !== 2'b00 || fb_start_address !== m_fb || init_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL aw_first resp=%0d fb=%h init=%b required 0/%h/1", r, fb_start_address, init_done, m_fb);
    end
    do_reset();
    write_txn(0, 32'hFFFF_FFFF, 4'h0, 3, 0, 0, r, c);
    void'(model_write(0, 32'hFFFF_FFFF, 4'h0));
    tests_run++;
    if (r !== 2'b00 || fb_start_address !== m_fb || init_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_strb_init resp=%0d fb=%h init=%b required 0/%h/1", r, fb_start_address, init_done, m_fb);
    end
    write_txn(0, 32'h1B00_0000, 4'hF, 3, 0, 0, r, c);
    void'(model_write(0, 32'h1B00_0000, 4'hF));
    tests_run++;
    if (r !== 2'b00 || fb_start_address !== 32'h1B00_0000) begin
      tests_failed++;
      $display("FAIL w_first resp=%0d fb=%h required 0/1b000000", r, fb_start_address);
    end
  endtask

  task automatic test_strobe_backpressure();
    logic [1:0] r; int c;
    write_txn(2, 32'hAABB_CCDD, 4'b0101, 0, 0, 5, r, c);
    void'(model_write(2, 32'hAABB_CCDD, 4'b0101));
    tests_run++;
    if (r !== 2'b00 || gp_regs[31:0] !== 32'h00BB_00DD || gp_regs[31:0] !== m_gp[0]) begin
      tests_failed++;
      $display("FAIL strobe_gp2 resp=%0d gp2=%h required 0/00bb00dd", r, gp_regs[31:0]);
    end
  endtask

  task automatic test_trigger();
    logic [1:0] r; logic [31:0] d; int c0, c1, c2, cnt, w;
    c0 = trig_count;
    write_txn(1, 32'h3, 4'hF, 0, 0, 0, r, c1);
    void'(model_write(1, 32'h3, 4'hF));
    tests_run++;
    if (one_shot_state !== 1'b1 || one_shot_trigger !== 1'b1) begin
      tests_failed++;
      $display("FAIL trig_start state=%b trig=%b required 1/1", one_shot_state, one_shot_trigger);
    end
    read_txn(1, 0, d, r);
    tests_run++;
    if (d !== 32'h3 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL ctrl_read_busy data=%h resp=%0d required 3/0", d, r);
    end
    w = 0;
    while (one_shot_trigger === 1'b1 && w < 100) begin @(posedge aclk); #1; w++; end
    cnt = trig_count - c0;
    tests_run++;
    if (cnt !== PL) begin
      tests_failed++;
      $display("FAIL trig_length got %0d cycles required %0d", cnt, PL);
    end
    read_txn(1, 0, d, r);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("FAIL ctrl_read_idle data=%h required 1", d);
    end
    c0 = trig_count;
    write_txn(1, 32'h3, 4'hF, 0, 0, 0, r, c1);
    w = 0;
    while (trig_count - c0 < 8 && w < 100) begin @(posedge aclk); #1; w++; end
    write_txn(1, 32'h3, 4'hF, 0, 0, 0, r, c2);
    w = 0;
    while (one_shot_trigger === 1'b1 && w < 100) begin @(posedge aclk); #1; w++; end
    cnt = trig_count - c0;
    tests_run++;
    if (cnt !== (c2 - c1) + PL) begin
      tests_failed++;
      $display("FAIL retrigger_length got %0d cycles required %0d", cnt, (c2 - c1) + PL);
    end
  endtask

  task automatic test_status_unmapped();
    logic [1:0] r; logic [31:0] d; int c;
    status_in = 32'h1234_5678;
    read_txn(NR, 2, d, r);
    tests_run++;
    if (d !== 32'h1234_5678 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL status_read data=%h resp=%0d required 12345678/0", d, r);
    end
    write_txn(NR, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, r, c);
    tests_run++;
    if (r !== model_write(NR, 32'hFFFF_FFFF, 4'hF) || fb_start_address !== m_fb || gp_regs[31:0] !== m_gp[0]) begin
      tests_failed++;
      $display("FAIL status_write resp=%0d fb=%h required 0/%h", r, fb_start_address, m_fb);
    end
    read_txn(NR + 1, 0, d, r);
    tests_run++;
    if (d !== 32'h0 || r !== 2'b10) begin
      tests_failed++;
      $display("FAIL unmapped_read data=%h resp=%0d required 0/2", d, r);
    end
    write_txn(NR + 1, 32'hDEAD_BEEF, 4'hF, 0, 2, 0, r, c);
    tests_run++;
    if (r !== model_write(NR + 1, 32'hDEAD_BEEF, 4'hF) || fb_start_address !== m_fb) begin
      tests_failed++;
      $display("FAIL unmapped_write resp=%0d fb=%h required 2/%h", r, fb_start_address, m_fb);
    end
  endtask

  task automatic test_random();
    logic [1:0] r, er; logic [31:0] d, ed, wd_v; logic [3:0] s; int idx, c;
    for (int n = 0; n < 40; n++) begin
      status_in = $urandom;
      idx = $urandom_range(0, NR + 1);
      wd_v = $urandom;
      if (idx == 1) wd_v[1] = 1'b0;
      s = 4'($urandom_range(0, 15));
      write_txn(idx, wd_v, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r, c);
      er = model_write(idx, wd_v, s);
      tests_run++;
      if (r !== er) begin
        tests_failed++;
        $display("FAIL rand_bresp idx=%0d got %0d required %0d", idx, r, er);
      end
      idx = $urandom_range(0, NR + 2);
      read_txn(idx, $urandom_range(0, 2), d, r);
      model_read(idx, ed, er);
      tests_run++;
      if (d !== ed || r !== er) begin
        tests_failed++;
        $display("FAIL rand_read idx=%0d got %h/%0d required %h/%0d", idx, d, r, ed, er);
      end
      for (int i = 0; i < NR-2; i++) begin
        tests_run++;
        if (gp_regs[i*32 +: 32] !== m_gp[i]) begin
          tests_failed++;
          $display("FAIL rand_gp%0d got %h required %h", i + 2, gp_regs[i*32 +: 32], m_gp[i]);
        end
      end
      tests_run++;
      if (fb_start_address !== m_fb || init_done !== m_init || one_shot_state !== m_state) begin
        tests_failed++;
        $display("FAIL rand_ctrl fb=%h init=%b state=%b required %h/%b/%b",
                 fb_start_address, init_done, one_shot_state, m_fb, m_init, m_state);
      end
    end
  endtask

  task automatic test_reset_mid();
    awaddr = AW'(3 * 4); wdata = 32'hDEAD_BEEF; wstrb = 4'hF; bready = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge aclk); #1;
    araddr = '0; arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pending bvalid=%b rvalid=%b required 1/1", bvalid, rvalid);
    end
    do_reset();
    tests_run++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_hs bvalid=%b rvalid=%b awready=%b wready=%b arready=%b required 0/0/1/1/1",
               bvalid, rvalid, awready, wready, arready);
    end
    tests_run++;
    if (gp_regs !== '0 || fb_start_address !== m_fb || init_done !== 1'b0 || one_shot_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_regs gp=%h fb=%h init=%b required 0/%h/0", gp_regs, fb_start_address, init_done, m_fb);
    end
    awaddr = '0; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    do_reset();
    wdata = 32'h5555_5555; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    tests_run++;
    if (bvalid !== 1'b0 || init_done !== 1'b0 || fb_start_address !== FB0) begin
      tests_failed++;
      $display("FAIL abandoned_aw bvalid=%b init=%b fb=%h required 0/0/%h", bvalid, init_done, fb_start_address, FB0);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_write_order();
    test_strobe_backpressure();
    test_trigger();
    test_status_unmapped();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
